// File: rtl/pipelined_control.sv
// Pipelined RV32I control: decodes in Decode, registers the control word into Execute,
// resolves branches, sequences multi-cycle loads and delays RegWE to Writeback.
// Optional macro CTRL_SIGNED_BRANCH_EN makes BLT/BGE legal.
module pipelined_control #(
  parameter int unsigned WB_DEPTH    = 1,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned CNT_W       = 3
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [6:0] op_D,
  input  logic [2:0] funct3_D,
  input  logic       funct7b5_D,
  input  logic       stall_D,
  input  logic       flush_E,
  input  logic       zero_E,
  input  logic       negative_E,
  output logic [1:0] ImmFormatD,
  output logic       RegWE_E,
  output logic       OpBSrcE,
  output logic [1:0] ExPathE,
  output logic [2:0] ALUFuncE,
  output logic       MemWriteE,
  output logic       PCSrcE,
  output logic       RegWE_W,
  output logic       stall_F,
  output logic       illegal_E
);

  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [CNT_W-1:0] LoadWait = CNT_W'(MEM_LATENCY - 1);

  typedef struct packed {
    logic       reg_we;
    logic       op_b_src;
    logic [1:0] ex_path;
    logic [2:0] alu_func;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [2:0] funct3;
    logic       illegal;
  } ctrl_t;

  ctrl_t                word_d, e_d, e_q;
  logic [1:0]           imm_fmt_d;
  logic                 load_d, legal, alu_ok, br_ok, br_cond;
  logic [2:0]           alu_f;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic [WB_DEPTH-1:0]  wb_d, wb_q;
  logic                 load_wait, e_bubble, wb_in;

  always_comb begin
    word_d    = '0;
    imm_fmt_d = 2'b00;
    load_d    = 1'b0;
    legal     = 1'b1;
    alu_ok    = 1'b1;
    alu_f     = 3'b000;
    br_ok     = 1'b0;
    case (funct3_D)
      3'b000:  alu_f = (op_D == OpReg && funct7b5_D) ? 3'b001 : 3'b000;
      3'b010:  alu_f = 3'b001;
      3'b100:  alu_f = 3'b100;
      3'b110:  alu_f = 3'b011;
      3'b111:  alu_f = 3'b010;
      default: alu_ok = 1'b0;
    endcase
    case (funct3_D)
      3'b000, 3'b001: br_ok = 1'b1;
`ifdef CTRL_SIGNED_BRANCH_EN
      3'b100, 3'b101: br_ok = 1'b1;
`endif
      default:        br_ok = 1'b0;
    endcase
    word_d.funct3 = funct3_D;
    case (op_D)
      OpImm, OpReg: begin
        legal           = alu_ok;
        word_d.reg_we   = 1'b1;
        word_d.op_b_src = (op_D == OpImm);
        word_d.alu_func = alu_f;
      end
      OpLoad: begin
        word_d.reg_we   = 1'b1;
        word_d.op_b_src = 1'b1;
        word_d.ex_path  = 2'b01;
        load_d          = 1'b1;
      end
      OpStore: begin
        word_d.op_b_src  = 1'b1;
        imm_fmt_d        = 2'b01;
        word_d.mem_write = 1'b1;
      end
      OpBranch: begin
        legal           = br_ok;
        imm_fmt_d       = 2'b10;
        word_d.alu_func = 3'b001;
        word_d.branch   = 1'b1;
      end
      OpJal: begin
        word_d.reg_we  = 1'b1;
        word_d.ex_path = 2'b10;
        imm_fmt_d      = 2'b11;
        word_d.jump    = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // Unsupported encodings become a clean bubble that only flags illegal.
    if (!legal) begin
      word_d         = '0;
      word_d.illegal = 1'b1;
      imm_fmt_d      = 2'b00;
      load_d         = 1'b0;
    end
  end

  always_comb begin
    br_cond = 1'b0;
    case (e_q.funct3)
      3'b000:  br_cond = zero_E;
      3'b001:  br_cond = !zero_E;
`ifdef CTRL_SIGNED_BRANCH_EN
      3'b100:  br_cond = negative_E;
      3'b101:  br_cond = !negative_E;
`endif
      default: br_cond = 1'b0;
    endcase
    PCSrcE = e_q.jump | (e_q.branch & br_cond);
  end

`ifndef CTRL_SIGNED_BRANCH_EN
  logic unused_negative;
  assign unused_negative = negative_E;
`endif

  assign load_wait = |cnt_q;
  assign e_bubble  = flush_E | PCSrcE;
  // Only the cycle an instruction leaves Execute forwards its RegWE; aborted loads never do.
  assign wb_in     = e_q.reg_we & ~load_wait & ~(stall_D & ~e_bubble);

  always_comb begin
    e_d   = e_q;
    cnt_d = cnt_q;
    if (e_bubble) begin
      e_d   = '0;
      cnt_d = '0;
    end else if (load_wait) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (!stall_D) begin
      e_d   = word_d;
      cnt_d = load_d ? LoadWait : '0;
    end
  end

  always_comb begin
    wb_d    = wb_q;
    wb_d[0] = wb_in;
    for (int unsigned i = 1; i < WB_DEPTH; i++) wb_d[i] = wb_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      e_q   <= '0;
      cnt_q <= '0;
      wb_q  <= '0;
    end else begin
      e_q   <= e_d;
      cnt_q <= cnt_d;
      wb_q  <= wb_d;
    end
  end

  assign ImmFormatD = imm_fmt_d;
  assign RegWE_E    = e_q.reg_we;
  assign OpBSrcE    = e_q.op_b_src;
  assign ExPathE    = e_q.ex_path;
  assign ALUFuncE   = e_q.alu_func;
  assign MemWriteE  = e_q.mem_write;
  assign illegal_E  = e_q.illegal;
  assign stall_F    = load_wait;
  assign RegWE_W    = wb_q[WB_DEPTH-1];

endmodule

// File: tb/tb_pipelined_control.sv
// Self-checking bench for pipelined_control: directed test-plan steps followed by random
// stimulus, all checked each cycle against a behavioural instruction-level model.
module tb_pipelined_control;

  localparam int WB = 2;
  localparam int ML = 3;
`ifdef CTRL_SIGNED_BRANCH_EN
  localparam bit Signed = 1'b1;
`else
  localparam bit Signed = 1'b0;
`endif

  localparam logic [6:0] OPIMM = 7'b0010011, OP = 7'b0110011, LOAD = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111;

  logic clk, nreset, funct7b5_D, stall_D, flush_E, zero_E, negative_E;
  logic [6:0] op_D;
  logic [2:0] funct3_D;
  logic [1:0] ImmFormatD, ExPathE;
  logic [2:0] ALUFuncE;
  logic RegWE_E, OpBSrcE, MemWriteE, PCSrcE, RegWE_W, stall_F, illegal_E;

  pipelined_control #(.WB_DEPTH(WB), .MEM_LATENCY(ML), .CNT_W(3)) dut (
    .clk(clk), .nreset(nreset), .op_D(op_D), .funct3_D(funct3_D), .funct7b5_D(funct7b5_D),
    .stall_D(stall_D), .flush_E(flush_E), .zero_E(zero_E), .negative_E(negative_E),
    .ImmFormatD(ImmFormatD), .RegWE_E(RegWE_E), .OpBSrcE(OpBSrcE), .ExPathE(ExPathE),
    .ALUFuncE(ALUFuncE), .MemWriteE(MemWriteE), .PCSrcE(PCSrcE), .RegWE_W(RegWE_W),
    .stall_F(stall_F), .illegal_E(illegal_E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction as seen by the model: what each field means architecturally.
  typedef struct packed {
    bit we, bsrc, mw, ld, br, jp, ill;
    bit [1:0] path, imm;
    bit [2:0] alu, f3;
  } inst_t;

  int n_vec = 0;
  int n_err = 0;
  inst_t m_e;
  int m_wait;
  bit m_wb[$];

  function automatic inst_t ref_decode(bit [6:0] op, bit [2:0] f3, bit f7);
    inst_t r = '0;
    bit alu_known = 1'b1;
    bit [2:0] alu = 3'd0;
    case (f3)
      3'd0: alu = (op == OP && f7) ? 3'd1 : 3'd0;
      3'd2: alu = 3'd1;
      3'd4: alu = 3'd4;
      3'd6: alu = 3'd3;
      3'd7: alu = 3'd2;
      default: alu_known = 1'b0;
    endcase
    case (op)
      OPIMM, OP: if (alu_known) begin r.we = 1; r.bsrc = (op == OPIMM); r.alu = alu; end
                 else r.ill = 1;
      LOAD:  begin r.we = 1; r.bsrc = 1; r.path = 2'd1; r.ld = 1; end
      STORE: begin r.bsrc = 1; r.imm = 2'd1; r.mw = 1; end
      BR:    if (f3 == 0 || f3 == 1 || (Signed && (f3 == 4 || f3 == 5))) begin
               r.imm = 2'd2; r.alu = 3'd1; r.br = 1; r.f3 = f3;
             end else r.ill = 1;
      JAL:   begin r.we = 1; r.path = 2'd2; r.imm = 2'd3; r.jp = 1; end
      default: r.ill = 1;
    endcase
    return r;
  endfunction

  function automatic bit ref_taken(inst_t e, bit z, bit n);
    if (e.jp) return 1'b1;
    if (!e.br) return 1'b0;
    case (e.f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return n;
      3'd5: return !n;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_e = '0;
    m_wait = 0;
    m_wb.delete();
    for (int i = 0; i < WB; i++) m_wb.push_back(1'b0);
  endtask

  task automatic drive(input bit r, input bit [6:0] o, input bit [2:0] f, input bit f7,
                       input bit s, input bit fl, input bit z, input bit n);
    nreset = r; op_D = o; funct3_D = f; funct7b5_D = f7;
    stall_D = s; flush_E = fl; zero_E = z; negative_E = n;
    #1;
  endtask

  // Compare every output with the model mid-cycle, then advance the model one clock.
  task automatic tick();
    bit pc, leaves, retire;
    @(negedge clk);
    pc = ref_taken(m_e, zero_E, negative_E);
    chk("ImmFormatD", ImmFormatD, ref_decode(op_D, funct3_D, funct7b5_D).imm);
    chk("RegWE_E", RegWE_E, m_e.we);
    chk("OpBSrcE", OpBSrcE, m_e.bsrc);
    chk("ExPathE", ExPathE, m_e.path);
    chk("ALUFuncE", ALUFuncE, m_e.alu);
    chk("MemWriteE", MemWriteE, m_e.mw);
    chk("illegal_E", illegal_E, m_e.ill);
    chk("PCSrcE", PCSrcE, pc);
    chk("stall_F", stall_F, m_wait > 0);
    chk("RegWE_W", RegWE_W, m_wb[WB-1]);
    if (!nreset) model_reset();
    else begin
      leaves = flush_E || pc || (m_wait == 0 && !stall_D);
      retire = leaves && m_wait == 0 && m_e.we;
      m_wb.push_front(retire);
      void'(m_wb.pop_back());
      if (flush_E || pc) begin
        m_e = '0;
        m_wait = 0;
      end else if (m_wait > 0) m_wait--;
      else if (!stall_D) begin
        m_e = ref_decode(op_D, funct3_D, funct7b5_D);
        m_wait = m_e.ld ? ML - 1 : 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  bit [6:0] ops [7];

  initial begin
    ops = '{OPIMM, OP, LOAD, STORE, BR, JAL, 7'h7f};
    drive(0, OP, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    model_reset();
    tick(); tick();
    chk("rst_regwe_e", RegWE_E, 0);
    chk("rst_stall_f", stall_F, 0);
    chk("rst_regwe_w", RegWE_W, 0);
    chk("rst_illegal", illegal_E, 0);

    // ADD then SUB, RegWE_W two cycles later
    drive(1, OP, 0, 0, 0, 0, 0, 0); tick();
    chk("add_alu", ALUFuncE, 3'b000); chk("add_we", RegWE_E, 1); chk("add_w_early", RegWE_W, 0);
    drive(1, OP, 0, 1, 0, 0, 0, 0); tick();
    chk("sub_alu", ALUFuncE, 3'b001); chk("sub_we", RegWE_E, 1);
    drive(1, STORE, 2, 0, 0, 0, 0, 0); tick();
    chk("add_w", RegWE_W, 1); chk("store_mw", MemWriteE, 1);
    tick(); chk("sub_w", RegWE_W, 1);
    tick(); chk("store_w", RegWE_W, 0);

    // BEQ taken then not taken
    drive(1, BR, 0, 0, 0, 0, 1, 0); tick();
    drive(1, OP, 0, 0, 0, 0, 1, 0); chk("beq_taken", PCSrcE, 1);
    tick(); chk("beq_bubble", RegWE_E, 0); chk("beq_pulse", PCSrcE, 0);
    tick();
    drive(1, BR, 0, 0, 0, 0, 0, 0); tick();
    drive(1, STORE, 2, 0, 0, 0, 0, 0); chk("beq_not_taken", PCSrcE, 0);
    tick(); chk("beq_fallthru", MemWriteE, 1);

    // LOAD followed by ADD with a 3-cycle memory
    drive(1, LOAD, 2, 0, 0, 0, 0, 0); tick();
    chk("ld_stall0", stall_F, 1); chk("ld_path", ExPathE, 2'b01);
    drive(1, OP, 0, 0, 0, 0, 0, 0); tick();
    chk("ld_stall1", stall_F, 1); chk("ld_hold1", ExPathE, 2'b01);
    tick(); chk("ld_stall2", stall_F, 0); chk("ld_hold2", ExPathE, 2'b01); chk("ld_w0", RegWE_W, 0);
    tick(); chk("ld_add_in", ExPathE, 2'b00); chk("ld_add_we", RegWE_E, 1); chk("ld_w1", RegWE_W, 0);
    drive(1, STORE, 2, 0, 0, 0, 0, 0); tick(); chk("ld_w_once", RegWE_W, 1);
    tick(); chk("ld_add_w", RegWE_W, 1);
    tick(); chk("ld_store_w", RegWE_W, 0);

    // stall_D hold, then stall_D with flush_E
    drive(1, OP, 4, 0, 0, 0, 0, 0); tick(); chk("xor_alu", ALUFuncE, 3'b100);
    drive(1, OP, 7, 0, 1, 0, 0, 0); tick(); chk("stall_hold1", ALUFuncE, 3'b100);
    tick(); chk("stall_hold2", ALUFuncE, 3'b100);
    drive(1, OP, 7, 0, 1, 1, 0, 0); tick();
    chk("flush_wins_we", RegWE_E, 0); chk("flush_wins_alu", ALUFuncE, 0);

    // Illegal opcode and BLT
    drive(1, 7'h7f, 0, 0, 0, 0, 0, 0); tick();
    chk("ill_flag", illegal_E, 1); chk("ill_we", RegWE_E, 0); chk("ill_mw", MemWriteE, 0);
    drive(1, BR, 4, 0, 0, 0, 0, 1); tick();
    drive(1, STORE, 2, 0, 0, 0, 0, 1);
    chk("blt_illegal", illegal_E, !Signed); chk("blt_taken", PCSrcE, Signed);
    tick();

    // flush_E during load wait aborts the load
    drive(1, LOAD, 2, 0, 0, 0, 0, 0); tick(); chk("abort_stall", stall_F, 1);
    drive(1, STORE, 2, 0, 0, 1, 0, 0); tick();
    chk("abort_stall_clr", stall_F, 0); chk("abort_bubble", RegWE_E, 0);
    drive(1, STORE, 2, 0, 0, 0, 0, 0); tick(); chk("abort_w0", RegWE_W, 0);
    tick(); chk("abort_w1", RegWE_W, 0);

    // Reset mid-load-wait, then JAL
    drive(1, LOAD, 2, 0, 0, 0, 0, 0); tick(); chk("rl_stall", stall_F, 1);
    drive(0, LOAD, 2, 0, 0, 0, 0, 0); tick();
    chk("rl_stall_clr", stall_F, 0); chk("rl_we", RegWE_E, 0);
    chk("rl_path", ExPathE, 0); chk("rl_w", RegWE_W, 0);
    drive(1, JAL, 0, 0, 0, 0, 0, 0); tick();
    chk("jal_pc", PCSrcE, 1); chk("jal_path", ExPathE, 2'b10);
    drive(1, STORE, 2, 0, 0, 0, 0, 0); tick(); chk("jal_bubble", RegWE_E, 0);
    tick(); chk("jal_next", MemWriteE, 1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) != 0), ops[$urandom_range(0, 6)], 3'($urandom_range(0, 7)),
            1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0),
            1'($urandom), 1'($urandom));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
